seg7_scan_display: RTL and testbench

Parametrised time-multiplexed seven-segment driver. It is the next generation of the fixed two-by-four-digit display driver, with configurable digit count and refresh rate. It adds double-buffered value loading, leading-zero blanking and global blanking. It sits at top level, fed by datapath debug values (PC, write data, HI/LO) and driving the board's shared cathodes and per-digit anodes.

---
 rtl/seg7_scan_display.sv | 107 ++++++++++
 tb/tb_seg7_scan_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver: one digit lit per dwell period, value
// loaded through a shadow register, with leading-zero and global blanking.
module seg7_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic                    BlankZeros,
  input  logic                    Blank,
  output logic [6:0]              out7,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic [IDX_W-1:0]        ScanIdx
);

  localparam int               PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;

  logic                    tick;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    digit_off;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: seg_code = 7'h01;
      4'h1: seg_code = 7'h4F;
      4'h2: seg_code = 7'h12;
      4'h3: seg_code = 7'h06;
      4'h4: seg_code = 7'h4C;
      4'h5: seg_code = 7'h24;
      4'h6: seg_code = 7'h20;
      4'h7: seg_code = 7'h0F;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h04;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h60;
      4'hC: seg_code = 7'h31;
      4'hD: seg_code = 7'h42;
      4'hE: seg_code = 7'h30;
      4'hF: seg_code = 7'h38;
    endcase
  endfunction

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    idx_d    = idx_q;
    shadow_d = Load ? Value : shadow_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic any_nz;
    // NOTE: every comb output gets a default before any branch or loop, so no latch can be inferred.
    any_nz    = 1'b0;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz       = any_nz | (|shadow_q[4*i +: 4]);
      zero_from[i] = ~any_nz;
    end
  end

  // The display is built from pre-edge shadow/index, so a Load on a tick never tears a digit.
  always_comb begin
    nibble    = 4'(shadow_q >> {idx_q, 2'b00});
    digit_off = Blank || (BlankZeros && (idx_q != '0) && zero_from[idx_q]);
    seg_d     = digit_off ? 7'h7F : seg_code(nibble);
    en_d      = digit_off ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pre_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= 7'h7F;
      en_q     <= '1;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end

  assign out7    = seg_q;
  assign en_out  = en_q;
  assign ScanIdx = idx_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: an 8-digit/div-4 and a 4-digit/div-2
// instance share stimulus; a cycle-count reference model feeds per-instance queues.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value;
  logic        load, bz, blank;

  logic [6:0]  seg8, seg4;
  logic [7:0]  en8;
  logic [3:0]  en4;
  logic [2:0]  idx8;
  logic [1:0]  idx4;

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut8 (
    .Clk(clk), .Reset(rst_n), .Value(value), .Load(load), .BlankZeros(bz),
    .Blank(blank), .out7(seg8), .en_out(en8), .ScanIdx(idx8)
  );

  seg7_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(2)) dut4 (
    .Clk(clk), .Reset(rst_n), .Value(value[15:0]), .Load(load), .BlankZeros(bz),
    .Blank(blank), .out7(seg4), .en_out(en4), .ScanIdx(idx4)
  );

  typedef struct packed {
    logic [6:0]  seg;
    logic [15:0] en;
    logic [3:0]  idx;
  } exp_t;

  exp_t        q8[$], q4[$];
  exp_t        e8, e4;
  int          vectors = 0;
  int          miscompares = 0;
  int          k = 0;
  logic [31:0] shadow_m = '0;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [3:0] en4_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected display after the edge that follows k completed edges since reset release.
  function automatic exp_t predict(input logic [31:0] sh, input int kk, input int n,
                                   input int div, input logic blk, input logic bzero);
    exp_t e;
    int   digit;
    int   all_mask;
    logic hidden;
    digit    = (kk / div) % n;
    all_mask = (1 << n) - 1;
    hidden   = blk || (bzero && digit != 0 && (sh >> (4 * digit)) == 0);
    e.seg    = hidden ? 7'h7F : seg_tab[(sh >> (4 * digit)) & 15];
    e.en     = hidden ? 16'(all_mask) : 16'(all_mask & ~(1 << digit));
    e.idx    = 4'(((kk + 1) / div) % n);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        = 0;
      shadow_m = '0;
      q8.delete();
      q4.delete();
    end else begin
      q8.push_back(predict(shadow_m, k, 8, 4, blank, bz));
      q4.push_back(predict(shadow_m & 32'hFFFF, k, 4, 2, blank, bz));
      if (load) shadow_m = value;
      k++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("d8.one_low", 32'($countones(~en8) <= 1), 32'd1);
      check("d4.one_low", 32'($countones(~en4) <= 1), 32'd1);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        check("d8.out7", 32'(seg8), 32'(e8.seg));
        check("d8.en_out", 32'(en8), 32'(e8.en));
        check("d8.ScanIdx", 32'(idx8), 32'(e8.idx));
      end
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        check("d4.out7", 32'(seg4), 32'(e4.seg));
        check("d4.en_out", 32'(en4), 32'(e4.en));
        check("d4.ScanIdx", 32'(idx4), 32'(e4.idx));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out7_8"}, 32'(seg8), 32'h7F);
    check({tag, ".en8"}, 32'(en8), 32'hFF);
    check({tag, ".idx8"}, 32'(idx8), 32'h0);
    check({tag, ".out7_4"}, 32'(seg4), 32'h7F);
    check({tag, ".en4"}, 32'(en4), 32'hF);
    check({tag, ".idx4"}, 32'(idx4), 32'h0);
  endtask

  task automatic align_k(input int target);
    int guard;
    guard = 0;
    while ((k % 32) != target && guard < 64) begin
      edges(1);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    bz    = 1'b0;
    blank = 1'b0;

    edges(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first.en8", 32'(en8), 32'hFE);
    check("first.out7", 32'(seg8), 32'h01);
    #1;

    value = 32'h89ABCDEF; load = 1'b1; edges(1); load = 1'b0;
    edges(34);

    bz = 1'b1;
    value = 32'h000000A5; load = 1'b1; edges(1); load = 1'b0;
    edges(36);
    value = 32'h0; load = 1'b1; edges(1); load = 1'b0;
    edges(36);
    bz = 1'b0;

    // Load lands on the tick edge that ends digit 3's dwell.
    value = 32'h89ABCDEF; load = 1'b1; edges(1); load = 1'b0;
    align_k(15);
    value = 32'h11111111; load = 1'b1;
    @(posedge clk); #1;
    check("tear.old_digit", 32'(seg8), 32'h31);
    #1; load = 1'b0;
    @(posedge clk); #1;
    check("tear.new_digit", 32'(seg8), 32'h4F);
    #1;

    edges(5);
    blank = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("blank.en8", 32'(en8), 32'hFF);
      check("blank.en4", 32'(en4), 32'hF);
      #1;
    end
    blank = 1'b0;
    edges(10);

    align_k(22);
    check("pre_reset.en8", 32'(en8), 32'hDF);
    #1; rst_n = 1'b0; #1;
    check_reset_state("async_reset");
    edges(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("restart.en4", 32'(en4), 32'(en4_seq[i / 2]));
      check("restart.out7_4", 32'(seg4), 32'h01);
      if (i == 0) check("restart.en8", 32'(en8), 32'hFE);
      #1;
    end

    repeat (400) begin
      value = $urandom >> (4 * $urandom_range(0, 8));
      load  = ($urandom_range(0, 3) == 0);
      blank = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) bz = ~bz;
      edges(1);
    end
    load  = 1'b0;
    blank = 1'b0;
    edges(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
